// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared sizes, op-type codes and the per-entry record for the reservation station
package reservation_station_pkg;
  localparam int RS_SIZE = 8;
  localparam int ROB_W = 5;
  localparam int OP_W = 7;
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam logic [OP_W-1:0] OP_NONE = 7'd0;
  localparam logic [OP_W-1:0] OP_ADD = 7'd1;
  localparam logic [OP_W-1:0] OP_SUB = 7'd2;
  localparam logic [OP_W-1:0] OP_BEQ = 7'd10;
  localparam logic [OP_W-1:0] OP_JAL = 7'd20;
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [ROB_W-1:0] rob;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             qjb;
    logic [ROB_W-1:0] qj;
    logic             qkb;
    logic [ROB_W-1:0] qk;
  } rs_entry_t;
endpackage

// File: rtl/rs_priority_enc.sv
// rs_priority_enc: lowest-index set-bit finder returning {found, idx}
module rs_priority_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);
  always_comb begin
    found = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: out-of-order issue buffer snooping ALU/LSB broadcasts, one registered issue per cycle to the ALU
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_opcode,
  input  logic [31:0]      disp_pc,
  input  logic [31:0]      disp_imm,
  input  logic [ROB_W-1:0] disp_rob,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_qj_busy,
  input  logic             disp_qk_busy,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [ROB_W-1:0] disp_qk,
  output logic             rs_full,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_rob,
  input  logic [31:0]      cdb_alu_val,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_rob,
  input  logic [31:0]      cdb_lsb_val,
  output logic [OP_W-1:0]  alu_opcode,
  output logic [31:0]      alu_pc,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [31:0]      alu_imm,
  output logic [ROB_W-1:0] alu_name
);
  rs_entry_t ent [RS_SIZE];
  logic [RS_SIZE-1:0] busy, ready;
  logic free_found, iss_found;
  logic [IDX_W-1:0] free_idx, iss_idx;
  logic [IDX_W:0] cnt;
  logic [32:0] dj, dk;
  function automatic logic [32:0] snoop(input logic qb, input logic [ROB_W-1:0] q, input logic [31:0] v);
    return (qb && cdb_alu_valid && q == cdb_alu_rob) ? {1'b0, cdb_alu_val} :
           (qb && cdb_lsb_valid && q == cdb_lsb_rob) ? {1'b0, cdb_lsb_val} : {qb, v};
  endfunction
  always_comb begin
    cnt = '0;
    ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, busy[i]};
      ready[i] = busy[i] & ~ent[i].qjb & ~ent[i].qkb;
    end
  end
  assign rs_full = cnt >= (IDX_W + 1)'(RS_SIZE - 1);
  assign dj = snoop(disp_qj_busy, disp_qj, disp_vj);
  assign dk = snoop(disp_qk_busy, disp_qk, disp_vk);
  rs_priority_enc #(.N(RS_SIZE)) u_free (.req(~busy), .found(free_found), .idx(free_idx));
  rs_priority_enc #(.N(RS_SIZE)) u_iss (.req(ready), .found(iss_found), .idx(iss_idx));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      alu_opcode <= '0;
      alu_pc <= '0;
      alu_rs1 <= '0;
      alu_rs2 <= '0;
      alu_imm <= '0;
      alu_name <= '0;
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy <= '0;
        alu_opcode <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            {ent[i].qjb, ent[i].vj} <= snoop(ent[i].qjb, ent[i].qj, ent[i].vj);
            {ent[i].qkb, ent[i].vk} <= snoop(ent[i].qkb, ent[i].qk, ent[i].vk);
          end
        end
        alu_opcode <= iss_found ? ent[iss_idx].op : OP_NONE;
        if (iss_found) begin
          busy[iss_idx] <= 1'b0;
          alu_pc <= ent[iss_idx].pc;
          alu_rs1 <= ent[iss_idx].vj;
          alu_rs2 <= ent[iss_idx].vk;
          alu_imm <= ent[iss_idx].imm;
          alu_name <= ent[iss_idx].rob;
        end
        if (disp_valid && free_found) begin
          busy[free_idx] <= 1'b1;
          ent[free_idx] <= '{op: disp_opcode, pc: disp_pc, imm: disp_imm, rob: disp_rob,
                             vj: dj[31:0], vk: dk[31:0], qjb: dj[32], qj: disp_qj,
                             qkb: dk[32], qk: disp_qk};
        end
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst) rdy && disp_valid && !clear |-> free_found);
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Out-of-order issue buffer directly upstream of the ALU.
- Holds decoded arithmetic, branch and jump ops from dispatch until both source operands are known.
- Snoops result broadcasts from the ALU and the LSB.
- Issues at most one ready op per cycle on registered outputs that drive the ALU inputs (pc, rs1, rs2, imm, opcode, calc_name).

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16).
- ROB_W, 5, ROB tag width; matches the ALU calc_name width.
- OP_W, 7, internal op-type code width; 0 means "no op".

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- clear  in  1  branch-mispredict flush
- disp_valid  in  1  dispatch request this cycle
- disp_opcode  in  OP_W  op-type code
- disp_pc  in  32  instruction pc
- disp_imm  in  32  immediate
- disp_rob  in  ROB_W  destination ROB tag
- disp_vj / disp_vk  in  32  operand values (valid when the matching q_busy is 0)
- disp_qj_busy / disp_qk_busy  in  1  operand still pending
- disp_qj / disp_qk  in  ROB_W  producer tag of the pending operand
- rs_full  out  1  dispatch must stall
- cdb_alu_valid  in  1  ALU result broadcast valid
- cdb_alu_rob  in  ROB_W  ALU result tag
- cdb_alu_val  in  32  ALU result value
- cdb_lsb_valid  in  1  LSB result broadcast valid
- cdb_lsb_rob  in  ROB_W  LSB result tag
- cdb_lsb_val  in  32  LSB result value
- alu_opcode  out  OP_W  issued op; 0 = bubble
- alu_pc  out  32  issued pc
- alu_rs1  out  32  issued first operand
- alu_rs2  out  32  issued second operand
- alu_imm  out  32  issued immediate
- alu_name  out  ROB_W  issued ROB tag

Behaviour:
- Reset (asynchronous): all entries non-busy; every alu_* output is 0; rs_full is 0.
- State per entry: busy, opcode, pc, imm, rob, vj, vk, qj_busy, qj, qk_busy, qk.
- Dispatch:
  - On a clk edge with rdy and disp_valid and not clear, the request is written into the lowest-index non-busy entry.
  - If disp_qj_busy and a broadcast in the same cycle matches disp_qj, vj is captured from that broadcast and qj_busy is stored as 0. The same rule applies to k.
  - disp_valid while every entry is busy is a protocol violation: the request is dropped and a simulation assertion fires.
- Wakeup:
  - Each edge, every busy entry with qj_busy and qj equal to a valid broadcast tag captures that value and clears qj_busy. The same rule applies to k.
  - If both CDBs carry the same tag, the ALU broadcast wins.
- Select and issue:
  - An entry is ready when busy and not qj_busy and not qk_busy, using state as of the start of the cycle. Wakeups take effect one edge later; there is no same-cycle bypass into issue.
  - Each rdy edge, the lowest-index ready entry is copied to the alu_* registers and freed.
  - If no entry is ready, alu_opcode is 0 and the other alu_* outputs hold their previous values.
  - A slot freed by issue may be reused by a dispatch on the same edge; the free choice uses start-of-cycle busy state, so a slot freed this edge is not selected until the next edge.
- Latency:
  - A dispatch with both operands ready at edge E0 appears on the alu_* outputs after edge E1 (one cycle of occupancy).
  - An operand woken at edge Ew makes its entry issuable at Ew+1.
- rs_full is combinational: asserted when popcount(busy) >= RS_SIZE-1. This covers the one-cycle dispatch pipeline ahead of this block.
- clear takes priority over everything on that edge: all busy bits cleared, alu_opcode forced to 0, dispatch ignored.
- With rdy low, no entry, output or busy bit changes. rst still acts asynchronously.
- Reset or clear mid-operation discards all pending and just-issued work; no partial issue survives.

Decomposition:
- const_def.v (shared): OP_W, ROB_W, RS_SIZE and the op-type codes already consumed by the ALU. No new constants are local to this block.
- One sub-module, rs_priority_enc: parameterised lowest-index-set-bit finder returning {found, index}. It is instantiated twice, once on ~busy for the free slot and once on the ready vector.

Test Plan:
- Reset, then dispatch ADD (disp_vj=5, disp_vk=7, no pending operands, disp_rob=3) at E0 -> after E1: alu_opcode = ADD code, alu_rs1=5, alu_rs2=7, alu_name=3; the next cycle alu_opcode=0.
- Dispatch with qj_busy, qj=4, then cdb_alu_valid with rob=4, val=0x10 two cycles later -> issue exactly one edge after the broadcast, with alu_rs1=0x10.
- Dispatch in the same cycle as a matching cdb_lsb broadcast (rob=6, val=0xABCD) -> the entry stores a ready operand and issues after the next edge with alu_rs1=0xABCD.
- Fill RS_SIZE-1 entries, all blocked on tag 9 -> rs_full=1. Broadcast tag 9 -> entries issue in index order, one per cycle, over 7 cycles; rs_full drops once popcount falls below 7.
- Four blocked entries plus one ready entry; assert clear together with disp_valid -> alu_opcode=0, rs_full=0, no later issue; a fresh dispatch afterwards lands in entry 0.
- Hold rdy=0 for 3 cycles with a ready entry present -> alu_* outputs unchanged; issue occurs on the first edge after rdy returns high.
